// File: rtl/board_render_pkg.sv
// -----------------------------------------------------------------------------
// board_pkg
// Shared definitions for the board_render sequencer and its tile cursor:
//   - board geometry constants (GRID_W x GRID_H cells of TILE x TILE pixels)
//   - screen_sel encodings
//   - sequencer FSM state enum
// -----------------------------------------------------------------------------
package board_pkg;

  localparam int GRID_W = 20;
  localparam int GRID_H = 15;
  localparam int TILE   = 16;

  localparam logic [1:0] SCR_TITLE = 2'd0;
  localparam logic [1:0] SCR_GAME  = 2'd1;
  localparam logic [1:0] SCR_END   = 2'd2;
  localparam logic [1:0] SCR_BOARD = 2'd3;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_MAP_RD,
    ST_MAP_WAIT,
    ST_ISSUE,
    ST_WAIT_FIN,
    ST_GAP1,
    ST_GAP2,
    ST_NEXT,
    ST_DONE
  } state_e;

endpackage

// File: rtl/board_render_tile_cursor.sv
// -----------------------------------------------------------------------------
// tile_cursor
// Column/row walker over the board map plus the map RAM address.
// Ports:
//   clk_i     system clock
//   reset_ni  synchronous active-low reset (cursor back to cell 0,0)
//   clr_i     return to cell (0,0)
//   step_i    advance one cell, row-major (col wraps, row increments)
//   col_o     current column
//   row_o     current row
//   last_o    cursor sits on the final cell (GRID_W-1, GRID_H-1)
//   addr_o    row*GRID_W + col, the map RAM address of the current cell
// -----------------------------------------------------------------------------
module tile_cursor #(
  parameter int GRID_W = board_pkg::GRID_W,
  parameter int GRID_H = board_pkg::GRID_H,
  parameter int COL_W  = $clog2(GRID_W),
  parameter int ROW_W  = $clog2(GRID_H)
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic             clr_i,
  input  logic             step_i,
  output logic [COL_W-1:0] col_o,
  output logic [ROW_W-1:0] row_o,
  output logic             last_o,
  output logic [8:0]       addr_o
);
  import board_pkg::*;

  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic             col_end;

  assign col_end = (col_q == COL_W'(GRID_W - 1));

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (clr_i) begin
      col_d = '0;
      row_d = '0;
    end else if (step_i) begin
      if (col_end) begin
        col_d = '0;
        row_d = row_q + ROW_W'(1);
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  assign col_o  = col_q;
  assign row_o  = row_q;
  assign last_o = col_end && (row_q == ROW_W'(GRID_H - 1));
  assign addr_o = 9'(row_q) * 9'(GRID_W) + 9'(col_q);

endmodule

// File: rtl/board_render.sv
// -----------------------------------------------------------------------------
// board_render
// Sequencer and pixel mapper around the copy ROM-blit engine. Screens 0-2 are
// blitted in one copy pass; screen 3 (board mode) walks the GRID_W x GRID_H
// tile map from an external map RAM and blits one TILE x TILE tile per cell.
// Optional feature macro: BOARD_RENDER_SKIP_EMPTY_EN -- when defined, map
// cells holding tile index 0 are skipped (no copy_go, cell left unpainted).
// Ports:
//   clk, reset_n (sync, active-low)       clock / reset
//   start, screen_sel                     job request (sampled only in IDLE)
//   map_addr, map_data                    map RAM read port (1-cycle latency)
//   copy_go, copy_memory_select,
//   copy_tile_select                      command to copy
//   copy_colour, copy_offset,
//   copy_write_en, copy_finished          pixel stream / end pulse from copy
//   vga_x, vga_y, vga_colour, vga_plot    registered plot command to VGA
//   busy, done                            job status / 1-cycle completion
// -----------------------------------------------------------------------------
module board_render #(
  parameter int GRID_W = board_pkg::GRID_W,
  parameter int GRID_H = board_pkg::GRID_H,
  parameter int TILE   = board_pkg::TILE
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [1:0]  screen_sel,
  output logic [8:0]  map_addr,
  input  logic [3:0]  map_data,
  output logic        copy_go,
  output logic [1:0]  copy_memory_select,
  output logic [3:0]  copy_tile_select,
  input  logic [14:0] copy_colour,
  input  logic [16:0] copy_offset,
  input  logic        copy_write_en,
  input  logic        copy_finished,
  output logic [8:0]  vga_x,
  output logic [7:0]  vga_y,
  output logic [14:0] vga_colour,
  output logic        vga_plot,
  output logic        busy,
  output logic        done
);
  import board_pkg::*;

  localparam int COL_W = $clog2(GRID_W);
  localparam int ROW_W = $clog2(GRID_H);

  state_e           state_q, state_d;
  logic [1:0]       scr_q, scr_d;
  logic [3:0]       tile_q, tile_d;
  logic             cur_clr, cur_step, cur_last;
  logic [COL_W-1:0] cur_col;
  logic [ROW_W-1:0] cur_row;
  logic             board_mode;
  logic             we_gated;
  logic [8:0]       x_d;
  logic [7:0]       y_d;
  logic [8:0]       vga_x_q;
  logic [7:0]       vga_y_q;
  logic [14:0]      vga_colour_q;
  logic             vga_plot_q;

  tile_cursor #(
    .GRID_W (GRID_W),
    .GRID_H (GRID_H)
  ) u_cursor (
    .clk_i    (clk),
    .reset_ni (reset_n),
    .clr_i    (cur_clr),
    .step_i   (cur_step),
    .col_o    (cur_col),
    .row_o    (cur_row),
    .last_o   (cur_last),
    .addr_o   (map_addr)
  );

  assign board_mode = (scr_q == SCR_BOARD);

  always_comb begin
    state_d  = state_q;
    scr_d    = scr_q;
    tile_d   = tile_q;
    cur_clr  = 1'b0;
    cur_step = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          scr_d = screen_sel;
          if (screen_sel == SCR_BOARD) begin
            cur_clr = 1'b1;
            state_d = ST_MAP_RD;
          end else begin
            tile_d  = '0;
            state_d = ST_ISSUE;
          end
        end
      end
      ST_MAP_RD:   state_d = ST_MAP_WAIT;
      ST_MAP_WAIT: begin
        tile_d = map_data;
`ifdef BOARD_RENDER_SKIP_EMPTY_EN
        state_d = (map_data == 4'd0) ? ST_NEXT : ST_ISSUE;
`else
        state_d = ST_ISSUE;
`endif
      end
      // copy_go stays up until copy shows it has started (first write_en).
      // A finish seen here is accepted even though copy should never do it.
      ST_ISSUE: begin
        if (copy_finished)      state_d = ST_GAP1;
        else if (copy_write_en) state_d = ST_WAIT_FIN;
      end
      ST_WAIT_FIN: if (copy_finished) state_d = ST_GAP1;
      ST_GAP1:     state_d = ST_GAP2;
      // The last board cell goes straight to DONE so completion always lands
      // three cycles after the final finish, in either mode.
      ST_GAP2:     state_d = (board_mode && !cur_last) ? ST_NEXT : ST_DONE;
      ST_NEXT: begin
        if (cur_last) begin
          state_d = ST_DONE;
        end else begin
          cur_step = 1'b1;
          state_d  = ST_MAP_RD;
        end
      end
      ST_DONE:     state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      scr_q   <= '0;
      tile_q  <= '0;
    end else begin
      state_q <= state_d;
      scr_q   <= scr_d;
      tile_q  <= tile_d;
    end
  end

  assign copy_go            = (state_q == ST_ISSUE);
  assign copy_memory_select = scr_q;
  assign copy_tile_select   = tile_q;
  assign busy               = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign done               = (state_q == ST_DONE);

  assign we_gated = copy_write_en && busy;

  always_comb begin
    if (board_mode) begin
      x_d = 9'(cur_col) * 9'(TILE) + 9'(copy_offset[3:0]);
      y_d = 8'(cur_row) * 8'(TILE) + 8'(copy_offset[7:4]);
    end else begin
      x_d = copy_offset[8:0];
      y_d = copy_offset[16:9];
    end
  end

  // Stage boundary: copy pixel stream -> registered VGA plot command
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      vga_x_q      <= '0;
      vga_y_q      <= '0;
      vga_colour_q <= '0;
      vga_plot_q   <= 1'b0;
    end else begin
      vga_plot_q <= we_gated;
      if (we_gated) begin
        vga_x_q      <= x_d;
        vga_y_q      <= y_d;
        vga_colour_q <= copy_colour;
      end
    end
  end

  assign vga_x      = vga_x_q;
  assign vga_y      = vga_y_q;
  assign vga_colour = vga_colour_q;
  assign vga_plot   = vga_plot_q;

endmodule

// File: tb/tb_board_render.sv
module tb_board_render;

  localparam int GW    = 20;
  localparam int GH    = 15;
  localparam int NCELL = GW * GH;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [1:0]  screen_sel;
  logic [8:0]  map_addr;
  logic [3:0]  map_data;
  logic        copy_go;
  logic [1:0]  copy_memory_select;
  logic [3:0]  copy_tile_select;
  logic [14:0] copy_colour;
  logic [16:0] copy_offset;
  logic        copy_write_en;
  logic        copy_finished;
  logic [8:0]  vga_x;
  logic [7:0]  vga_y;
  logic [14:0] vga_colour;
  logic        vga_plot;
  logic        busy;
  logic        done;

  board_render dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .start              (start),
    .screen_sel         (screen_sel),
    .map_addr           (map_addr),
    .map_data           (map_data),
    .copy_go            (copy_go),
    .copy_memory_select (copy_memory_select),
    .copy_tile_select   (copy_tile_select),
    .copy_colour        (copy_colour),
    .copy_offset        (copy_offset),
    .copy_write_en      (copy_write_en),
    .copy_finished      (copy_finished),
    .vga_x              (vga_x),
    .vga_y              (vga_y),
    .vga_colour         (vga_colour),
    .vga_plot           (vga_plot),
    .busy               (busy),
    .done               (done)
  );

  always #5 clk = ~clk;

  // Map RAM model: one-cycle read latency.
  logic [3:0] map_mem [0:NCELL-1];
  always @(posedge clk) map_data <= (map_addr < 9'(NCELL)) ? map_mem[map_addr] : 4'd0;

  int   n_cmp = 0;
  int   n_err = 0;
  bit   op_active = 1'b0;
  bit   tb_board = 1'b0;
  logic [1:0] exp_msel = 2'd0;
  int   exp_cells[$];
  int   cur_cell = 0;
  int   go_cnt = 0;
  int   done_cnt = 0;
  logic prev_go = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit cell_issued(input int c);
`ifdef BOARD_RENDER_SKIP_EMPTY_EN
    return map_mem[c] != 4'd0;
`else
    return 1'b1;
`endif
  endfunction

  // Reference monitor: each plot command must mirror the previous cycle's
  // accepted copy pixel; each new copy_go must target the next expected cell.
  logic        m_we, m_act;
  logic [16:0] m_off;
  logic [14:0] m_col;
  int          ex, ey;
  always begin
    @(posedge clk);
    m_we  = copy_write_en;
    m_off = copy_offset;
    m_col = copy_colour;
    m_act = op_active && reset_n;
    #1;
    chk("plot", vga_plot, m_we && m_act);
    if (m_we && m_act) begin
      if (tb_board) begin
        ex = (cur_cell % GW) * 16 + int'(m_off[3:0]);
        ey = (cur_cell / GW) * 16 + int'(m_off[7:4]);
        if (cur_cell == 43 && m_off[7:0] == 8'h4A && map_mem[43] == 4'd2) begin
          chk("map_c3r2_x", vga_x, 58);
          chk("map_c3r2_y", vga_y, 36);
          chk("map_c3r2_tile", copy_tile_select, 2);
        end
      end else begin
        ex = int'(m_off[8:0]);
        ey = int'(m_off[16:9]);
      end
      chk("vga_x", vga_x, ex);
      chk("vga_y", vga_y, ey);
      chk("vga_colour", vga_colour, m_col);
    end
    if (copy_go && !prev_go) begin
      go_cnt++;
      chk("go_pending", exp_cells.size() != 0, 1);
      if (exp_cells.size() != 0) begin
        cur_cell = exp_cells.pop_front();
        chk("mem_sel", copy_memory_select, exp_msel);
        if (tb_board) begin
          chk("map_addr", map_addr, cur_cell);
          chk("tile_sel", copy_tile_select, map_mem[cur_cell]);
        end
      end
    end
    if (done) done_cnt++;
    prev_go = copy_go;
  end

  task automatic chk_zero(input string tag);
    chk({tag, "_go"}, copy_go, 0);
    chk({tag, "_msel"}, copy_memory_select, 0);
    chk({tag, "_tsel"}, copy_tile_select, 0);
    chk({tag, "_addr"}, map_addr, 0);
    chk({tag, "_x"}, vga_x, 0);
    chk({tag, "_y"}, vga_y, 0);
    chk({tag, "_col"}, vga_colour, 0);
    chk({tag, "_plot"}, vga_plot, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  // Behavioural copy engine: on go, emits 1..3 pixels then a finish pulse.
  // A stray start (screen 1) is injected mid-job; it must be ignored.
  task automatic copy_serve(input int stop_go, output int fin_cyc, output int done_cyc,
                            output bit to);
    int cyc = 0;
    int n_go = 0;
    int left = 0;
    bit cmb = 1'b0;
    bit first = 1'b0;
    to = 1'b1; fin_cyc = 0; done_cyc = 0;
    while (cyc < 20000) begin
      @(negedge clk);
      cyc++;
      copy_write_en = 1'b0;
      copy_finished = 1'b0;
      start         = (cyc == 40);
      screen_sel    = (cyc == 40) ? 2'd1 : 2'd3;
      if (done) begin
        done_cyc = cyc; to = 1'b0;
        break;
      end
      if (cmb) begin
        if (left > 0) begin
          copy_write_en = 1'b1;
          copy_offset   = first ? {9'($urandom), 8'h4A} : 17'($urandom);
          copy_colour   = 15'($urandom);
          first = 1'b0;
          left--;
        end else begin
          copy_finished = 1'b1;
          fin_cyc = cyc;
          cmb = 1'b0;
        end
      end else if (copy_go) begin
        cmb = 1'b1; first = 1'b1; n_go++;
        left = $urandom_range(1, 3);
        if (stop_go != 0 && n_go == stop_go) begin
          to = 1'b0;
          break;
        end
      end
    end
    start = 1'b0;
    screen_sel = 2'd3;
  endtask

  task automatic run_board(input int stop_go);
    int fc, dc, n_exp;
    bit to, first_iss, last_iss;
    exp_cells.delete();
    for (int c = 0; c < NCELL; c++) if (cell_issued(c)) exp_cells.push_back(c);
    n_exp     = exp_cells.size();
    first_iss = (n_exp > 0) && (exp_cells[0] == 0);
    last_iss  = (n_exp > 0) && (exp_cells[$] == NCELL - 1);
    tb_board = 1'b1; exp_msel = 2'd3; go_cnt = 0; done_cnt = 0;
    @(negedge clk);
    op_active = 1'b1; start = 1'b1; screen_sel = 2'd3;
    @(negedge clk);
    start = 1'b0;
    chk("b_busy", busy, 1);
    chk("b_go_rd", copy_go, 0);
    chk("b_addr0", map_addr, 0);
    @(negedge clk);
    chk("b_go_wait", copy_go, 0);
    @(negedge clk);
    if (first_iss) chk("b_go_lat", copy_go, 1);
    copy_serve(stop_go, fc, dc, to);
    chk("b_timeout", to, 0);
    if (stop_go == 0) begin
      op_active = 1'b0;
      if (last_iss) chk("b_done_lat", dc - fc, 3);
      chk("b_go_cnt", go_cnt, n_exp);
      chk("b_cells_left", exp_cells.size(), 0);
      @(negedge clk);
      chk("b_busy_end", busy, 0);
      chk("b_done_end", done, 0);
      chk("b_done_cnt", done_cnt, 1);
    end
  endtask

  task automatic random_map();
    for (int c = 0; c < NCELL; c++) map_mem[c] = 4'($urandom);
    map_mem[0]   = 4'($urandom_range(1, 15));
    map_mem[299] = 4'($urandom_range(1, 15));
    map_mem[43]  = 4'd2;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_go;
    reset_n = 1'b0; start = 1'b0; screen_sel = 2'd0;
    copy_write_en = 1'b0; copy_finished = 1'b0;
    copy_offset = '0; copy_colour = '0;
    for (int c = 0; c < NCELL; c++) map_mem[c] = 4'd0;
    repeat (3) @(negedge clk);
    chk_zero("rst");
    reset_n = 1'b1;

    // Full-screen job, screen 1.
    exp_cells.delete(); exp_cells.push_back(0);
    tb_board = 1'b0; exp_msel = 2'd1; done_cnt = 0;
    @(negedge clk);
    op_active = 1'b1; screen_sel = 2'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("f_go", copy_go, 1);
    chk("f_msel", copy_memory_select, 1);
    chk("f_busy", busy, 1);
    copy_write_en = 1'b1; copy_offset = {8'd5, 9'd7}; copy_colour = 15'h1234;
    @(negedge clk);
    copy_write_en = 1'b0;
    chk("f_x", vga_x, 7);
    chk("f_y", vga_y, 5);
    chk("f_col", vga_colour, 15'h1234);
    chk("f_plot", vga_plot, 1);
    chk("f_go_drop", copy_go, 0);
    copy_finished = 1'b1;
    @(negedge clk);
    copy_finished = 1'b0;
    chk("f_done1", done, 0);
    @(negedge clk);
    chk("f_done2", done, 0);
    @(negedge clk);
    chk("f_done3", done, 1);
    @(negedge clk);
    op_active = 1'b0;
    chk("f_done_end", done, 0);
    chk("f_busy_end", busy, 0);
    chk("f_done_cnt", done_cnt, 1);

    // write_en while idle must not plot.
    copy_write_en = 1'b1; copy_offset = 17'($urandom); copy_colour = 15'($urandom);
    @(negedge clk);
    copy_write_en = 1'b0;
    chk("idle_plot", vga_plot, 0);

    // Full board traversal with a random map.
    random_map();
    run_board(0);

    // Single non-empty cell at address 21 (col 1, row 1).
    for (int c = 0; c < NCELL; c++) map_mem[c] = 4'd0;
    map_mem[21] = 4'd5;
    run_board(0);
`ifdef BOARD_RENDER_SKIP_EMPTY_EN
    exp_go = 1;
`else
    exp_go = 300;
`endif
    chk("skip_go_cnt", go_cnt, exp_go);

    // Reset in the middle of tile 10, then restart from map address 0.
    random_map();
    run_board(11);
    reset_n = 1'b0; op_active = 1'b0;
    copy_write_en = 1'b0; copy_finished = 1'b0;
    @(negedge clk);
    chk_zero("rstmid");
    reset_n = 1'b1;
    exp_cells.delete();
    run_board(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/board_render.md
# board_render

Sequencer and pixel mapper wrapped around the `copy` ROM-blit engine. Issues `go`, `memory_select` and `tile_select` to `copy`, then waits for its `finished` pulse. Consumes copy's `colour`/`offset`/`write_en` stream and converts it into VGA-adapter plot commands. Screens 0–2 are blitted in a single pass. Board mode (screen 3) walks a 20×15 tile map held in an external map RAM and blits one 16×16 tile per map cell.

## Interface
Parameters:
- `GRID_W`, default 20: tiles per row.
- `GRID_H`, default 15: tile rows.
- `TILE`, default 16: tile edge in pixels. Fixed; the offset split relies on it.

Ports:
- `clk`, in, 1: system clock.
- `reset_n`, in, 1: synchronous, active-low reset.
- `start`, in, 1: single-cycle request; sampled only in IDLE.
- `screen_sel`, in, 2: 0/1/2 = title/game/end full screen; 3 = board mode.
- `map_addr`, out, 9: map RAM read address.
- `map_data`, in, 4: tile index; valid 1 cycle after `map_addr`.
- `copy_go`, out, 1: go to copy.
- `copy_memory_select`, out, 2: memory_select to copy.
- `copy_tile_select`, out, 4: tile_select to copy.
- `copy_colour`, in, 15: colour from copy.
- `copy_offset`, in, 17: offset from copy.
- `copy_write_en`, in, 1: write_en from copy.
- `copy_finished`, in, 1: finished pulse from copy.
- `vga_x`, out, 9: plot x coordinate.
- `vga_y`, out, 8: plot y coordinate.
- `vga_colour`, out, 15: plot colour.
- `vga_plot`, out, 1: plot strobe.
- `busy`, out, 1: high from start until done.
- `done`, out, 1: 1-cycle completion pulse.

## Operation
- Reset value of every output is 0. Internal state: FSM = IDLE, cursor col = row = 0.
- FSM states: IDLE, MAP_RD, MAP_WAIT, ISSUE, WAIT_FIN, GAP1, GAP2, NEXT, DONE.
- **IDLE**
  - `start`=1 and `screen_sel`≠3: latch `screen_sel`, go to ISSUE.
  - `start`=1 and `screen_sel`=3: clear the cursor, go to MAP_RD.
- **MAP_RD:** drive `map_addr = row*GRID_W + col` (9-bit, max 299).
- **MAP_WAIT:** latch `map_data` as the tile index.
- **ISSUE:**
  - Drive `copy_go`=1 and `copy_memory_select` (latched screen, or 3 in board mode).
  - Drive `copy_tile_select` = latched tile index.
  - Hold `copy_go` high until the first `copy_write_en`, then drop it.
- **WAIT_FIN:** wait for `copy_finished`.
- **GAP1, GAP2:** two cycles that let copy return to its WAIT state before any new `go`.
- **GAP2 exit:**
  - Full-screen mode: go to DONE.
  - Board mode: go to NEXT.
- **NEXT:**
  - col wraps at GRID_W-1 and row increments.
  - At (GRID_W-1, GRID_H-1), go to DONE; otherwise go to MAP_RD.
- **DONE:** `done`=1 for one cycle, then IDLE.
- `busy` = (state ≠ IDLE) & (state ≠ DONE).
- **Pixel mapping**, registered, applied whenever `copy_write_en`=1:
  - Full screen: `vga_x = copy_offset[8:0]`, `vga_y = copy_offset[16:9]`.
  - Board mode: `vga_x = col*16 + copy_offset[3:0]`, `vga_y = row*16 + copy_offset[7:4]`.
  - `vga_colour = copy_colour`.
- `copy_write_en` while busy=0 is ignored: `vga_plot` stays 0.
- `start` while busy is ignored.
- `reset_n`=0 mid-operation:
  - Next cycle: all outputs 0, FSM in IDLE, cursor cleared.
  - No partial-tile resume; the next `start` restarts at map address 0.

## Timing
- `vga_*` outputs lag `copy_write_en`/`copy_offset`/`copy_colour` by exactly 1 cycle. `vga_plot` is exactly a 1-cycle delay of the gated `copy_write_en`.
- Board mode: `start` to first `copy_go` is 3 cycles (MAP_RD, MAP_WAIT, ISSUE).
- Per-tile overhead outside copy's own busy time is 6 cycles: NEXT, MAP_RD, MAP_WAIT, ISSUE, GAP1, GAP2.
- `done` fires 3 cycles after the final `copy_finished` (GAP1, GAP2, DONE).
- `copy_finished` arriving in the same cycle `copy_go` first asserts is impossible by copy's protocol. If it occurs, it is still accepted.

## Configuration
- Macro: `BOARD_RENDER_SKIP_EMPTY_EN`.
- Defined: in MAP_WAIT, a tile index of 0 branches straight to NEXT. No `copy_go` is issued, so the cell is left unpainted.
- Undefined: every cell is blitted, including index 0. A full board issues exactly 300 `copy_go` assertions.

## Structure
- Shared package `board_pkg`:
  - FSM state enum.
  - `GRID_W`, `GRID_H`, `TILE` constants.
  - Screen-select encodings (`SCR_TITLE`, `SCR_GAME`, `SCR_END`, `SCR_BOARD`).
- One sub-module, `tile_cursor`: col/row counter with clear, step and last-cell flag, plus the `map_addr` multiply-add.

## Test plan
- **Reset:** hold `reset_n`=0 for 3 cycles, then release. All outputs are 0 and `busy`=0.
- **Full screen:** `screen_sel`=1, then `start`.
  - `copy_go`=1 with `copy_memory_select`=01.
  - `copy_write_en` with offset {y=5, x=7}, colour 0x1234 → next cycle `vga_x`=7, `vga_y`=5, `vga_colour`=0x1234, `vga_plot`=1.
  - `copy_finished` → `done` 3 cycles later.
- **Board mapping:** at cursor (col=3, row=2) with tile 2, a `copy_offset` of 0x4A → `vga_x`=58, `vga_y`=36, and `copy_tile_select`=2.
- **Traversal:** the copy model finishes every tile. `map_addr` steps 0..299 in order, `done` pulses once after the 300th finish, and `busy` falls.
- **`BOARD_RENDER_SKIP_EMPTY_EN`:** map all 0 except address 21 = 5.
  - With the macro: exactly one `copy_go`, with `copy_tile_select`=5 and `vga` coordinates based at (16,16).
  - Without the macro: 300 `copy_go` assertions.
- **Reset mid-board:** assert `reset_n`=0 during tile 10.
  - Next cycle: outputs 0, FSM in IDLE.
  - A new `start` with `screen_sel`=3 presents `map_addr`=0.
